// File: rtl/branch_cond_unit_pkg.sv
// ==== branch_cond_unit_pkg : shared condition codes and FSM states ====
// Revision 1.0
`default_nettype none

package branch_cond_unit_pkg;

  localparam logic [2:0] COND_ZR = 3'd0;
  localparam logic [2:0] COND_NZ = 3'd1;
  localparam logic [2:0] COND_PL = 3'd2;
  localparam logic [2:0] COND_MI = 3'd3;
  localparam logic [2:0] COND_GE = 3'd4;
  localparam logic [2:0] COND_LE = 3'd5;
  localparam logic [2:0] COND_AL = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  // Codes at or above this value are reserved.
  localparam int unsigned COND_RSVD_MIN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ==== branch_cond_eval : combinational branch-condition resolver ====
// Revision 1.0
`default_nettype none

module branch_cond_eval
  import branch_cond_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COND_W = 4
) (
  input  logic [COND_W-1:0] i_code,
  input  logic [DATA_W-1:0] i_operand,
  output logic              o_result,
  output logic              o_illegal
);

  logic w_sign;
  logic w_zero;

  assign w_sign = i_operand[DATA_W-1];
  assign w_zero = (i_operand == '0);

  always_comb begin
    o_illegal = (32'(i_code) >= COND_RSVD_MIN);
    o_result  = 1'b0;
    case (i_code[2:0])
      COND_ZR: o_result = w_zero;
      COND_NZ: o_result = !w_zero;
      COND_PL: o_result = !w_sign && !w_zero;
      COND_MI: o_result = w_sign;
      COND_GE: o_result = !w_sign;
      COND_LE: o_result = w_sign || w_zero;
      COND_AL: o_result = 1'b1;
      COND_NV: o_result = 1'b0;
      default: o_result = 1'b0;
    endcase
    if (o_illegal) begin
      o_result = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_cond_unit.sv
// ==== branch_cond_unit : registered branch evaluator with handshake and stats ====
// Revision 1.0
`default_nettype none

module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int   DATA_W   = 32,
  parameter int   COND_LSB = 19,
  parameter int   COND_W   = 4,
  parameter logic INIT_VAL = 1'b0,
  parameter int   CNT_W    = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              con_in,
  input  logic [31:0]       ir,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              con_ack,
  output logic              con_out,
  output logic              con_valid,
  output logic              busy,
  output logic              cond_illegal,
  output logic              overrun,
  output logic [CNT_W-1:0]  eval_count,
  output logic [CNT_W-1:0]  taken_count
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COND_W-1:0]   r_cond;
  logic [DATA_W-1:0]   r_op;
  logic                r_con_out;
  logic                r_valid;
  logic                r_illegal;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_eval_cnt;
  logic [CNT_W-1:0]    r_taken_cnt;
  logic                w_capture;
  logic                w_drop;
  logic                w_result;
  logic                w_illegal;
  logic                w_unused_ir;

  // Only the condition field of ir is consumed.
  assign w_unused_ir = ^ir;

  branch_cond_eval #(
    .DATA_W (DATA_W),
    .COND_W (COND_W)
  ) u_eval (
    .i_code    (r_cond),
    .i_operand (r_op),
    .o_result  (w_result),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (con_in) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        w_state_nxt = ST_HOLD;
        w_drop      = con_in;
      end
      ST_HOLD: begin
        if (con_ack) begin
          w_capture   = con_in;
          w_state_nxt = con_in ? ST_EVAL : ST_IDLE;
        end else begin
          w_drop = con_in;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_cond      <= '0;
      r_op        <= '0;
      r_con_out   <= INIT_VAL;
      r_valid     <= 1'b0;
      r_illegal   <= 1'b0;
      r_overrun   <= 1'b0;
      r_eval_cnt  <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_cond <= ir[COND_LSB +: COND_W];
        r_op   <= bus_data;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (r_state == ST_EVAL) begin
        r_valid   <= 1'b1;
        r_illegal <= w_illegal;
        // Reserved codes leave the previous result and the statistics untouched.
        if (!w_illegal) begin
          r_con_out <= w_result;
          if (r_eval_cnt != '1) begin
            r_eval_cnt <= r_eval_cnt + CNT_W'(1);
          end
          if (w_result && (r_taken_cnt != '1)) begin
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
          end
        end
      end else if ((r_state == ST_HOLD) && con_ack) begin
        r_valid   <= 1'b0;
        r_illegal <= 1'b0;
      end
    end
  end

  assign con_out      = r_con_out;
  assign con_valid    = r_valid;
  assign busy         = (r_state != ST_IDLE);
  assign cond_illegal = r_illegal;
  assign overrun      = r_overrun;
  assign eval_count   = r_eval_cnt;
  assign taken_count  = r_taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
// ==== tb_branch_cond_unit : scoreboard bench for branch_cond_unit ====
// Revision 1.0
`default_nettype none

module tb_branch_cond_unit;

  logic        clk;
  logic        clear;
  logic        con_in;
  logic [31:0] ir;
  logic [31:0] bus_data;
  logic        con_ack;

  logic        con_out, con_valid, busy, cond_illegal, overrun;
  logic [15:0] eval_count, taken_count;
  logic        s_out, s_valid, s_busy, s_ill, s_ovr;
  logic [1:0]  s_eval, s_taken;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic out;
    logic ill;
    int   ev;
    int   tk;
  } exp_t;

  exp_t q[$];
  logic m_out   = 1'b0;
  int   m_eval  = 0;
  int   m_taken = 0;
  logic prev_valid = 1'b0;

  branch_cond_unit #(.CNT_W(16)) dut (
    .clock(clk), .clear(clear), .con_in(con_in), .ir(ir), .bus_data(bus_data),
    .con_ack(con_ack), .con_out(con_out), .con_valid(con_valid), .busy(busy),
    .cond_illegal(cond_illegal), .overrun(overrun),
    .eval_count(eval_count), .taken_count(taken_count)
  );

  branch_cond_unit #(.CNT_W(2)) dut_sat (
    .clock(clk), .clear(clear), .con_in(con_in), .ir(ir), .bus_data(bus_data),
    .con_ack(con_ack), .con_out(s_out), .con_valid(s_valid), .busy(s_busy),
    .cond_illegal(s_ill), .overrun(s_ovr),
    .eval_count(s_eval), .taken_count(s_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Monitor: every fresh result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!clear) begin
      if (con_valid && !prev_valid) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_con_out", 32'(con_out), 32'(e.out));
          chk("sb_cond_illegal", 32'(cond_illegal), 32'(e.ill));
          chk("sb_eval_count", 32'(eval_count), 32'(e.ev));
          chk("sb_taken_count", 32'(taken_count), 32'(e.tk));
          chk("sb_sat_eval_count", 32'(s_eval), 32'(sat3(e.ev)));
          chk("sb_sat_taken_count", 32'(s_taken), 32'(sat3(e.tk)));
        end
      end
      prev_valid = con_valid;
    end
  end

  task automatic push_exp(input logic [3:0] code, input logic res);
    exp_t e;
    if (code >= 4'd8) begin
      e.ill = 1'b1;
    end else begin
      e.ill   = 1'b0;
      m_out   = res;
      m_eval  = m_eval + 1;
      m_taken = m_taken + (res ? 1 : 0);
    end
    e.out = m_out;
    e.ev  = m_eval;
    e.tk  = m_taken;
    q.push_back(e);
  endtask

  // Entered at a falling edge; leaves 1 time unit after the capturing rising edge.
  task automatic start(input logic [3:0] code, input logic [31:0] data, input logic ack,
                       input logic res);
    ir       = (32'h5A5A_5A5A & ~(32'hF << 19)) | (32'(code) << 19);
    bus_data = data;
    con_in   = 1'b1;
    con_ack  = ack;
    push_exp(code, res);
    @(posedge clk);
    #1;
    con_in  = 1'b0;
    con_ack = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!con_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!con_valid) chk(name, 32'(con_valid), 32'd1);
  endtask

  task automatic do_ack();
    con_ack = 1'b1;
    @(posedge clk);
    #1;
    con_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_one(input logic [3:0] code, input logic [31:0] data, input logic res);
    start(code, data, 1'b0, res);
    wait_valid("timeout_valid");
    do_ack();
  endtask

  logic [31:0] ops   [5] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                             32'h8000_0000, 32'hFFFF_FFFF};
  // Bit k is the expected result of condition code k on the matching operand.
  logic [7:0]  masks [5] = '{8'h71, 8'h56, 8'h56, 8'h6A, 8'h6A};

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    clear = 1'b1; con_in = 1'b0; con_ack = 1'b0; ir = '0; bus_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_con_out", 32'(con_out), 32'd0);
    chk("rst_con_valid", 32'(con_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_eval_count", 32'(eval_count), 32'd0);
    clear = 1'b0;
    @(negedge clk);

    // Latency and operand isolation.
    start(4'd1, 32'd5, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_valid_cycle1", 32'(con_valid), 32'd0);
    chk("lat_busy_cycle1", 32'(busy), 32'd1);
    bus_data = 32'd0;
    @(negedge clk);
    chk("lat_valid_cycle2", 32'(con_valid), 32'd1);
    repeat (2) @(negedge clk);
    chk("hold_con_out", 32'(con_out), 32'd1);
    chk("hold_con_valid", 32'(con_valid), 32'd1);
    do_ack();
    chk("ack_con_valid", 32'(con_valid), 32'd0);
    chk("ack_con_out_kept", 32'(con_out), 32'd1);
    chk("ack_busy", 32'(busy), 32'd0);

    // Sign sweep.
    for (int i = 0; i < 5; i++) begin
      m = masks[i];
      for (int c = 0; c < 8; c++) begin
        run_one(4'(c), ops[i], m[c]);
      end
    end

    // Back-to-back.
    start(4'd6, 32'h1234, 1'b0, 1'b1);
    wait_valid("timeout_b2b_first");
    start(4'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("b2b_eval_valid", 32'(con_valid), 32'd0);
    chk("b2b_eval_busy", 32'(busy), 32'd1);
    wait_valid("timeout_b2b_second");
    chk("b2b_con_out", 32'(con_out), 32'd1);
    do_ack();

    // Overrun.
    start(4'd7, 32'h123, 1'b0, 1'b0);
    wait_valid("timeout_ovr");
    chk("ovr_before", 32'(overrun), 32'd0);
    con_in = 1'b1;
    @(posedge clk);
    #1;
    con_in = 1'b0;
    @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_still_hold", 32'(con_valid), 32'd1);
    chk("ovr_out_kept", 32'(con_out), 32'd0);
    do_ack();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reserved code after a taken result.
    run_one(4'd6, 32'd0, 1'b1);
    start(4'd9, 32'd0, 1'b0, 1'b0);
    wait_valid("timeout_rsvd");
    chk("rsvd_illegal", 32'(cond_illegal), 32'd1);
    chk("rsvd_out_kept", 32'(con_out), 32'd1);
    do_ack();
    chk("rsvd_illegal_clear", 32'(cond_illegal), 32'd0);
    run_one(4'd15, 32'hFFFF_FFFF, 1'b0);

    chk("sat_eval_count", 32'(s_eval), 32'd3);
    chk("sat_taken_count", 32'(s_taken), 32'd3);

    // Asynchronous clear while holding a result.
    start(4'd6, 32'd0, 1'b0, 1'b1);
    wait_valid("timeout_rst_hold");
    #2;
    clear = 1'b1;
    #1;
    chk("arst_con_out", 32'(con_out), 32'd0);
    chk("arst_con_valid", 32'(con_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_eval_count", 32'(eval_count), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_sat_eval", 32'(s_eval), 32'd0);
    m_out = 1'b0; m_eval = 0; m_taken = 0;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    run_one(4'd4, 32'd3, 1'b1);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
Clocked, parametrised conditional-branch evaluator for the datapath control unit. On an evaluate strobe it captures the IR condition field and the bus operand. It then resolves a branch condition and holds a registered taken/not-taken result with a valid/acknowledge handshake. It also keeps saturating evaluation and taken statistics counters.

Parameters:
DATA_W, 32, operand width in bits (minimum 2); operand is treated as two's-complement.
COND_LSB, 19, bit position of the condition field LSB within ir.
COND_W, 4, condition field width (minimum 3); codes at or above 8 are reserved.
INIT_VAL, 0, reset value of con_out.
CNT_W, 16, width of the statistics counters.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
clear  in  1  reset, asynchronous, active-high.
con_in  in  1  evaluate strobe, sampled on the clock edge.
ir  in  32  instruction register; the condition is ir[COND_LSB+COND_W-1:COND_LSB].
bus_data  in  DATA_W  operand under test.
con_ack  in  1  control unit has consumed the result.
con_out  out  1  branch-taken result (registered).
con_valid  out  1  con_out holds a fresh, unconsumed result.
busy  out  1  unit is in EVAL or HOLD.
cond_illegal  out  1  the result in HOLD came from a reserved code.
overrun  out  1  sticky: a strobe was dropped; cleared only by clear.
eval_count  out  CNT_W  number of legal evaluations, saturating.
taken_count  out  CNT_W  number of evaluations that resolved taken, saturating.

Behaviour:
- Reset (async, clear=1):
  - state=IDLE, con_out=INIT_VAL, all other outputs 0.
  - Any in-flight evaluation is abandoned; no counter update occurs.
- States: IDLE, EVAL, HOLD. busy=1 in EVAL and HOLD.
- IDLE:
  - con_in=1 at an edge: register the condition field and bus_data, go to EVAL.
  - Otherwise stay in IDLE.
- EVAL (exactly one cycle):
  - Resolve the condition from the captured values only; later ir/bus_data changes have no effect.
  - Register con_out, set con_valid=1, update counters, go to HOLD.
- HOLD:
  - con_out and con_valid are stable until acknowledged.
  - con_ack=1 and con_in=0: go to IDLE; con_valid=0 next cycle; con_out retains its value.
  - con_ack=1 and con_in=1: capture the new operands and go directly to EVAL (back-to-back case); con_valid=0 during that EVAL cycle.
  - con_in=1 without con_ack: strobe dropped, overrun set to 1, stay in HOLD.
- con_in=1 during EVAL: strobe dropped, overrun set to 1.
- con_ack outside HOLD: ignored.
- Latency: con_in sampled at edge N gives con_valid=1 after edge N+1, i.e. visible in cycle N+2.
- Conditions (s = MSB of captured operand, z = operand==0):
  - 0 zr: z.
  - 1 nz: !z.
  - 2 pl: !s && !z (strictly positive).
  - 3 mi: s.
  - 4 ge: !s.
  - 5 le: s || z.
  - 6 al: 1.
  - 7 nv: 0.
- Reserved codes (>=8):
  - con_out keeps its previous value; con_valid still asserts.
  - cond_illegal=1 for that HOLD period.
  - Counters are not updated.
- cond_illegal clears when HOLD is left.
- Counters:
  - eval_count increments by 1 per legal EVAL.
  - taken_count increments when the legal result is 1.
  - Both stick at 2^CNT_W-1; no wrap.
- Width boundaries:
  - Most negative value (1 followed by zeros) is mi/le true, pl/ge false.
  - All-ones is mi true, nz true.

Decomposition:
- Shared package: condition code constants (COND_ZR..COND_NV), the state enumeration, and the reserved-code threshold.
- One natural sub-module: branch_cond_eval, purely combinational. Inputs are the code and operand; outputs are result and illegal. It is reused by the pipeline's early-branch logic.
- Counters and the FSM stay in branch_cond_unit.

Test Plan:
- Reset mid-HOLD: evaluate code 6, raise clear while con_valid=1 -> con_out=INIT_VAL, con_valid=0, eval_count=0, state IDLE immediately (asynchronous).
- Sign sweep with codes 0..7 on bus_data 0, 1, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF -> e.g. code 2 on 0x80000000 gives 0; code 5 on 0 gives 1; code 3 on 0xFFFFFFFF gives 1.
- Latency/hold: con_in at edge 0 with code 1, bus_data=5 -> con_valid=1 in cycle 2, con_out=1. bus_data changes to 0 afterwards -> con_out unchanged; con_ack -> con_valid=0 next cycle.
- Back-to-back: in HOLD assert con_ack and con_in together with code 0, bus_data=0 -> one EVAL cycle with con_valid=0, then con_valid=1, con_out=1, eval_count=2.
- Overrun and reserved code: con_in in HOLD without ack -> overrun=1 and remains 1 after a later ack. Code 9 -> cond_illegal=1, con_out unchanged, counters unchanged.
- Saturation with CNT_W=2: five code-6 evaluations -> eval_count=3, taken_count=3.
